// File: rtl/llr_stream_scheduler_if.sv
// Bundles the symbol-issue side, the LCU lane inputs and the serial LLR stream of
// llr_stream_scheduler. The scheduler connects to the slave modport.
//
// Handshake rules, shared by both streams:
//   A beat moves on a rising clock edge when valid and ready are both high.
//   A producer holds its valid high, together with its payload, until that edge.
//   The consumer drives ready without looking at valid in the same cycle.
//   Symbol stream:  producer i_sym_valid/i_Mode, consumer o_sym_ready.
//   LLR stream:     producer o_llr_valid/o_llr/o_llr_idx/o_llr_last, consumer i_llr_ready.
interface llr_stream_scheduler_if #(
  parameter int LLR_W = 19
);
  logic             i_sym_valid;
  logic             o_sym_ready;
  logic [2:0]       i_Mode;
  logic [2:0]       o_lcu_mode;
  logic [LLR_W-1:0] i_LLR_0;
  logic [LLR_W-1:0] i_LLR_1;
  logic [LLR_W-1:0] i_LLR_2;
  logic [LLR_W-1:0] i_LLR_3;
  logic [LLR_W-1:0] i_LLR_4;
  logic [LLR_W-1:0] i_LLR_5;
  logic [LLR_W-1:0] o_llr;
  logic [2:0]       o_llr_idx;
  logic             o_llr_valid;
  logic             o_llr_last;
  logic             i_llr_ready;
  logic             o_overflow;
  logic             o_dbg_state;

  modport slave (
    input  i_sym_valid, i_Mode, i_llr_ready,
    input  i_LLR_0, i_LLR_1, i_LLR_2, i_LLR_3, i_LLR_4, i_LLR_5,
    output o_sym_ready, o_lcu_mode, o_llr, o_llr_idx, o_llr_valid, o_llr_last,
    output o_overflow, o_dbg_state
  );

  modport master (
    output i_sym_valid, i_Mode, i_llr_ready,
    output i_LLR_0, i_LLR_1, i_LLR_2, i_LLR_3, i_LLR_4, i_LLR_5,
    input  o_sym_ready, o_lcu_mode, o_llr, o_llr_idx, o_llr_valid, o_llr_last,
    input  o_overflow, o_dbg_state
  );
endinterface

// File: rtl/llr_stream_scheduler.sv
// llr_stream_scheduler: tracks symbols through the fixed-latency metric/LCU pipeline
// with a tag shift register, captures the six LCU lanes into a small FIFO when each
// symbol's LLRs appear, and serialises every entry as nbits beats on a valid/ready
// stream. Upstream issue is limited by credits, because the LCU pipeline cannot stall.
module llr_stream_scheduler #(
  parameter int LLR_wordlength = 19,
  parameter int bit_num        = 6,
  parameter int PIPE_LAT       = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  llr_stream_scheduler_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(PIPE_LAT + 1);
  localparam int SW = $clog2(FIFO_DEPTH + PIPE_LAT + 1) + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  // Mode to LLR count; modes 6 and 7 behave as mode 5.
  function automatic logic [2:0] nbits_of(input logic [2:0] mode);
    logic [2:0] n;
    case (mode)
      3'd0, 3'd1: n = 3'd2;
      3'd2:       n = 3'd3;
      3'd3:       n = 3'd4;
      3'd4:       n = 3'd5;
      default:    n = 3'd6;
    endcase
    return n;
  endfunction

  // Registers and their next values.
  logic [PIPE_LAT-1:0]       tag_valid_q, tag_valid_d;
  logic [2:0]                tag_mode_q [PIPE_LAT];
  logic [2:0]                tag_mode_d [PIPE_LAT];
  logic [LLR_wordlength-1:0] llr_mem_q  [FIFO_DEPTH][bit_num];
  logic [LLR_wordlength-1:0] llr_mem_d  [FIFO_DEPTH][bit_num];
  logic [2:0]                nbits_mem_q [FIFO_DEPTH];
  logic [2:0]                nbits_mem_d [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             fifo_count_q, fifo_count_d;
  logic [2:0]                k_q, k_d;
  logic [0:0]                state_q, state_d;
  logic                      overflow_q, overflow_d;

  // Combinational helpers.
  logic [LLR_wordlength-1:0] lcu_lane [bit_num];
  logic [IW-1:0]             inflight;
  logic                      sym_ready;
  logic                      accept;
  logic                      capture;
  logic                      fifo_full;
  logic                      wr_en;
  logic [2:0]                head_nbits;
  logic [2:0]                head_idx;
  logic                      head_last;
  logic                      llr_valid;
  logic                      beat_fire;
  logic                      pop;

  // Gather the LCU lane inputs into an indexable array.
  always_comb begin
    lcu_lane[0] = bus.i_LLR_0;
    lcu_lane[1] = bus.i_LLR_1;
    lcu_lane[2] = bus.i_LLR_2;
    lcu_lane[3] = bus.i_LLR_3;
    lcu_lane[4] = bus.i_LLR_4;
    lcu_lane[5] = bus.i_LLR_5;
  end

  // Credits: FIFO occupancy plus symbols still inside the LCU pipeline.
  // Derived only from registers, so ready carries no path from i_llr_ready.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + IW'(tag_valid_q[i]);
    end
    sym_ready = (SW'(fifo_count_q) + SW'(inflight)) < SW'(FIFO_DEPTH);
    accept    = bus.i_sym_valid & sym_ready;
  end

  // Tag pipeline: an accepted symbol or a bubble enters stage 0 every cycle.
  always_comb begin
    tag_valid_d[0] = accept;
    tag_mode_d[0]  = accept ? bus.i_Mode : 3'd0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_mode_d[i]  = tag_mode_q[i-1];
    end
  end

  // The LCU latches its mode one cycle before the LLRs appear.
  generate
    if (PIPE_LAT == 1) begin : g_lat_one
      assign bus.o_lcu_mode = bus.i_Mode;
    end else begin : g_lat_many
      assign bus.o_lcu_mode = tag_mode_q[PIPE_LAT-2];
    end
  endgenerate

  // Serialiser view of the FIFO head.
  always_comb begin
    head_nbits = nbits_mem_q[rd_ptr_q];
    head_idx   = 3'(bit_num) - head_nbits + k_q;
    head_last  = (k_q == head_nbits - 3'd1);
    llr_valid  = (state_q == S_STREAM);
    beat_fire  = llr_valid & bus.i_llr_ready;
    pop        = beat_fire & head_last;
  end

  // FIFO write, pointer and occupancy update; a capture into a full FIFO is dropped.
  always_comb begin
    capture     = tag_valid_q[PIPE_LAT-1];
    fifo_full   = (fifo_count_q == CW'(FIFO_DEPTH));
    wr_en       = capture & ~fifo_full;
    llr_mem_d   = llr_mem_q;
    nbits_mem_d = nbits_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_en) begin
      llr_mem_d[wr_ptr_q]   = lcu_lane;
      nbits_mem_d[wr_ptr_q] = nbits_of(tag_mode_q[PIPE_LAT-1]);
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    overflow_d = overflow_q | (capture & fifo_full);
  end

  // Serialiser FSM and per-entry beat counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) state_d = S_STREAM;
      end
      default: begin
        if (beat_fire) begin
          k_d = head_last ? 3'd0 : k_q + 3'd1;
        end
        if (pop && !wr_en && fifo_count_q == CW'(1)) state_d = S_IDLE;
      end
    endcase
  end

  // Stream outputs are forced to zero while idle.
  assign bus.o_sym_ready = sym_ready;
  assign bus.o_llr_valid = llr_valid;
  assign bus.o_llr       = llr_valid ? llr_mem_q[rd_ptr_q][head_idx] : '0;
  assign bus.o_llr_idx   = llr_valid ? head_idx : 3'd0;
  assign bus.o_llr_last  = llr_valid & head_last;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_dbg_state = state_q;

  // State registers; reset discards in-flight symbols and buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_mode_q[i] <= 3'd0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        nbits_mem_q[e] <= 3'd0;
        for (int l = 0; l < bit_num; l++) llr_mem_q[e][l] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      k_q          <= 3'd0;
      state_q      <= S_IDLE;
      overflow_q   <= 1'b0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_mode_q   <= tag_mode_d;
      llr_mem_q    <= llr_mem_d;
      nbits_mem_q  <= nbits_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      k_q          <= k_d;
      state_q      <= state_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_llr_stream_scheduler.sv
// Bench for llr_stream_scheduler. A behavioural model keeps the symbols still in
// the LCU pipeline (with the cycle each one is captured) and the flat list of
// LLR beats still owed downstream; a per-cycle monitor compares the DUT with it.
module tb_llr_stream_scheduler;
  localparam int W     = 19;
  localparam int PL    = 4;
  localparam int DEPTH = 8;
  localparam int BW    = 1 + 3 + W;   // {last, idx, llr}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] lanes [6];

  llr_stream_scheduler_if #(.LLR_W(W)) bus ();

  llr_stream_scheduler #(
    .LLR_wordlength(W), .bit_num(6), .PIPE_LAT(PL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  assign bus.i_LLR_0 = lanes[0];
  assign bus.i_LLR_1 = lanes[1];
  assign bus.i_LLR_2 = lanes[2];
  assign bus.i_LLR_3 = lanes[3];
  assign bus.i_LLR_4 = lanes[4];
  assign bus.i_LLR_5 = lanes[5];

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [BW-1:0] exp_q [$];
  typedef struct { int cap; logic [2:0] mode; } pend_t;
  pend_t pend_q [$];
  int nb_tab [8] = '{2, 2, 3, 4, 5, 6, 6, 6};

  logic [2:0] t2_modes [4] = '{3'd5, 3'd4, 3'd1, 3'd2};
  int t2_cnt [4] = '{6, 5, 2, 3};
  int t2_idx [4] = '{0, 1, 4, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < 6; l++) lanes[l] = W'($urandom);
  endtask

  // Scoreboard: compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin : monitor
    int fifo_n;
    int n;
    int lane;
    logic rdy_exp;
    logic [2:0] lm_exp;
    pend_t p;
    if (!rst_n) begin
      check("rst_llr_valid", 32'(bus.o_llr_valid), 32'd0);
      check("rst_sym_ready", 32'(bus.o_sym_ready), 32'd1);
      check("rst_overflow",  32'(bus.o_overflow), 32'd0);
      check("rst_lcu_mode",  32'(bus.o_lcu_mode), 32'd0);
      check("rst_llr",       32'(bus.o_llr), 32'd0);
      exp_q.delete();
      pend_q.delete();
    end else begin
      fifo_n = 0;
      foreach (exp_q[i]) if (exp_q[i][BW-1]) fifo_n++;
      rdy_exp = (fifo_n + pend_q.size()) < DEPTH;
      lm_exp = 3'd0;
      foreach (pend_q[i]) if (pend_q[i].cap == cyc + 1) lm_exp = pend_q[i].mode;
      check("llr_valid", 32'(bus.o_llr_valid), 32'(exp_q.size() != 0));
      check("sym_ready", 32'(bus.o_sym_ready), 32'(rdy_exp));
      check("lcu_mode",  32'(bus.o_lcu_mode), 32'(lm_exp));
      check("overflow",  32'(bus.o_overflow), 32'd0);
      if (exp_q.size() != 0) begin
        check("llr",      32'(bus.o_llr), 32'(exp_q[0][W-1:0]));
        check("llr_idx",  32'(bus.o_llr_idx), 32'(exp_q[0][W+2:W]));
        check("llr_last", 32'(bus.o_llr_last), 32'(exp_q[0][BW-1]));
      end
      if (exp_q.size() != 0 && bus.i_llr_ready) void'(exp_q.pop_front());
      if (pend_q.size() != 0 && pend_q[0].cap == cyc) begin
        n = nb_tab[pend_q[0].mode];
        for (int b = 0; b < n; b++) begin
          lane = 6 - n + b;
          exp_q.push_back({b == n - 1, 3'(lane), lanes[lane]});
        end
        void'(pend_q.pop_front());
      end
      if (bus.i_sym_valid && rdy_exp) begin
        p.cap  = cyc + PL;
        p.mode = bus.i_Mode;
        pend_q.push_back(p);
      end
    end
    cyc++;
  end

  // Stimulus
  initial begin : driver
    int first_j;
    int nbeat;
    int nsym;
    int acc;
    int lasts;
    int got_cnt [8];
    int got_idx [8];

    bus.i_sym_valid = 1'b0;
    bus.i_Mode      = 3'd0;
    bus.i_llr_ready = 1'b0;
    for (int l = 0; l < 6; l++) lanes[l] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single mode-5 symbol with lanes 10..15
    for (int l = 0; l < 6; l++) lanes[l] = W'(10 + l);
    bus.i_llr_ready = 1'b1;
    first_j = -1;
    nbeat = 0;
    for (int j = 0; j < 16; j++) begin
      step();
      bus.i_sym_valid = (j == 0);
      bus.i_Mode = 3'd5;
      @(negedge clk);
      if (bus.o_llr_valid) begin
        if (first_j < 0) first_j = j;
        check("t1_value", 32'(bus.o_llr), 32'(10 + nbeat));
        check("t1_idx",   32'(bus.o_llr_idx), 32'(nbeat));
        check("t1_last",  32'(bus.o_llr_last), 32'(nbeat == 5));
        nbeat++;
      end
    end
    check("t1_first_beat_cycle", 32'(first_j), 32'd5);
    check("t1_beat_count", 32'(nbeat), 32'd6);

    // Back-to-back modes 5,4,1,2
    nsym = 0;
    nbeat = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      bus.i_sym_valid = (j < 4);
      if (j < 4) bus.i_Mode = t2_modes[j];
      rand_lanes();
      @(negedge clk);
      if (bus.o_llr_valid && nsym < 8) begin
        if (nbeat == 0) got_idx[nsym] = int'(bus.o_llr_idx);
        nbeat++;
        if (bus.o_llr_last) begin
          got_cnt[nsym] = nbeat;
          nsym++;
          nbeat = 0;
        end
      end
    end
    check("t2_symbols", 32'(nsym), 32'd4);
    for (int s = 0; s < 4; s++) begin
      check("t2_beats", 32'(got_cnt[s]), 32'(t2_cnt[s]));
      check("t2_first_idx", 32'(got_idx[s]), 32'(t2_idx[s]));
    end

    // Stalled downstream: credits must stop issue at eight symbols
    bus.i_llr_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      bus.i_sym_valid = 1'b1;
      bus.i_Mode = 3'($urandom_range(0, 7));
      rand_lanes();
      @(negedge clk);
      if (bus.i_sym_valid && bus.o_sym_ready) acc++;
    end
    check("t3_accepted", 32'(acc), 32'd8);
    check("t3_ready_low", 32'(bus.o_sym_ready), 32'd0);
    lasts = 0;
    for (int j = 0; j < 70; j++) begin
      step();
      bus.i_sym_valid = 1'b0;
      bus.i_llr_ready = 1'b1;
      @(negedge clk);
      if (bus.o_llr_valid && bus.o_llr_last) lasts++;
    end
    check("t3_drained_symbols", 32'(lasts), 32'd8);

    // Random modes, continuous symbols, 50% downstream ready
    acc = 0;
    for (int j = 0; j < 20000 && acc < 1000; j++) begin
      step();
      bus.i_sym_valid = 1'b1;
      bus.i_Mode = 3'($urandom_range(0, 7));
      bus.i_llr_ready = 1'($urandom_range(0, 1));
      rand_lanes();
      @(negedge clk);
      if (bus.o_sym_ready) acc++;
    end
    check("t4_symbols_accepted", 32'(acc), 32'd1000);
    for (int j = 0; j < 100; j++) begin
      step();
      bus.i_sym_valid = 1'b0;
      bus.i_llr_ready = 1'b1;
      @(negedge clk);
    end

    // Reset mid-symbol with two symbols in flight
    for (int l = 0; l < 6; l++) lanes[l] = W'(100 + l);
    first_j = -1;
    nbeat = 0;
    for (int j = 0; j < 26; j++) begin
      step();
      bus.i_sym_valid = (j == 0 || j == 5 || j == 6 || j == 11);
      bus.i_Mode = (j == 11) ? 3'd3 : 3'd5;
      if (j == 8) rst_n = 1'b0;
      if (j == 10) rst_n = 1'b1;
      @(negedge clk);
      if (j == 7) check("t5_pre_reset_idx", 32'(bus.o_llr_idx), 32'd2);
      if (j == 8) begin
        check("t5_reset_valid", 32'(bus.o_llr_valid), 32'd0);
        check("t5_reset_ready", 32'(bus.o_sym_ready), 32'd1);
      end
      if (j > 8 && bus.o_llr_valid) begin
        if (first_j < 0) begin
          first_j = j;
          check("t5_first_idx", 32'(bus.o_llr_idx), 32'd2);
          check("t5_first_llr", 32'(bus.o_llr), 32'd102);
        end
        nbeat++;
      end
    end
    check("t5_first_beat_cycle", 32'(first_j), 32'd16);
    check("t5_beats", 32'(nbeat), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
